unidade_controle_param: RTL
===========================

UNIDADE_CONTROLE_PARAM -- requirements
Module: unidade_controle_param

Interface
REQ-001 Parameters SHALL be: N_JOGADAS, default 16, number of plays per game; T_TIMEOUT, default 5000, clock cycles allowed per play; T_RESULTADO, default 1000, clock cycles each result is shown; N_VIDAS, default 3, lives available in lives mode.
REQ-002 Ports SHALL be:
- clock, in, 1, system clock; all state updates on the rising edge.
- reset, in, 1, asynchronous, active-low reset.
- iniciar, in, 1, start/restart request.
- modo, in, 1, 0 = fixed-sequence mode, 1 = lives mode; sampled only in INICIAL when iniciar=1.
- fez_jogada, in, 1, player input strobe.
- jogada_igual_memoria, in, 1, datapath compare result.
- registraR, zeraR, liga_led, out, 1 each, datapath controls.
- pronto, acertou, errou, timeout, out, 1 each, board LEDs.
- endereco, out, clog2(N_JOGADAS), current play index.
- score, out, clog2(N_JOGADAS+1), number of correct plays.
- vidas, out, clog2(N_VIDAS+1), remaining lives.
- db_estado, out, 4, state code.
REQ-003 Only one clock SHALL exist; reset SHALL be asynchronous, active-low, with no synchronous reset path.

Function
REQ-004 FSM states and db_estado codes SHALL be: INICIAL 0, PREPARACAO 1, AGUARDA 5, REGISTRA 6, COMPARA 7, PROXIMA 8, CONTA 9, ACERTOU C, TIMEOUT_FIM D, ERROU E, FIM F. Any illegal code SHALL output B and go to INICIAL.
REQ-005 Transitions SHALL be:
- INICIAL goes to PREPARACAO if iniciar.
- PREPARACAO goes to AGUARDA.
- AGUARDA goes to REGISTRA if fez_jogada; otherwise on expiry to TIMEOUT_FIM (modo=0) or ERROU (modo=1).
- REGISTRA goes to COMPARA.
- COMPARA goes to CONTA on match, otherwise ERROU.
- CONTA goes to ACERTOU.
- ACERTOU and ERROU go, at result-timer end, to FIM if the game is over, otherwise PROXIMA.
- PROXIMA goes to AGUARDA.
- FIM and TIMEOUT_FIM go to INICIAL if iniciar.
REQ-006 A Moore output SHALL be 1 only in the listed states:
- registraR: REGISTRA.
- liga_led: AGUARDA.
- zeraR: INICIAL, PREPARACAO, PROXIMA, ACERTOU, ERROU.
- acertou: ACERTOU.
- errou: ERROU.
- pronto: FIM, TIMEOUT_FIM.
- timeout: TIMEOUT_FIM, and ERROU when entered by expiry.
REQ-007 The timeout counter SHALL clear in PREPARACAO, PROXIMA and REGISTRA, and SHALL increment each AGUARDA cycle. Expiry SHALL occur on the AGUARDA cycle where the count equals T_TIMEOUT-1, so the player gets exactly T_TIMEOUT cycles.
REQ-008 If fez_jogada=1 on the expiry cycle, the play SHALL win and the FSM SHALL go to REGISTRA.
REQ-009 The result timer SHALL clear in REGISTRA and on expiry entry to ERROU. ACERTOU and ERROU SHALL each last exactly T_RESULTADO cycles.
REQ-010 score SHALL clear in PREPARACAO and SHALL increment once per CONTA visit; its maximum is N_JOGADAS, so it never wraps.
REQ-011 endereco SHALL clear in PREPARACAO and SHALL increment once per PROXIMA visit. The game SHALL be over when endereco = N_JOGADAS-1, or in modo=1 when vidas = 0.
REQ-012 vidas SHALL load N_VIDAS in PREPARACAO. In modo=1 it SHALL decrement by 1 on each entry to ERROU, and never go below 0. In modo=0 it SHALL stay constant.
REQ-013 The internal modo register SHALL be written only in INICIAL when iniciar=1; changes to modo mid-game SHALL be ignored.
REQ-014 iniciar SHALL be ignored in every state except INICIAL, FIM and TIMEOUT_FIM.

Reset
REQ-015 While reset=0 the block SHALL hold:
- state INICIAL;
- all 1-bit outputs 0 except zeraR=1;
- endereco, score and both timers at 0;
- vidas at N_VIDAS;
- internal modo at 0;
- db_estado at 0.
REQ-016 Reset asserted mid-game SHALL take effect immediately with no completion of the current play. After release, the first transition SHALL require iniciar.

Structure
REQ-017 State encodings, db_estado codes and the B error code SHALL live in the shared game constants package, together with the default parameter values.
REQ-018 The four counters SHALL be instances of one generic sub-module, contador_m, with inputs zera, conta and carga plus its value, and outputs Q and fim. The FSM and output decode SHALL remain in unidade_controle_param.

Verification
Bench parameters: N_JOGADAS=4, T_TIMEOUT=8, T_RESULTADO=3, N_VIDAS=2.
REQ-019 modo=0, 4 correct plays -> score=4, endereco=3, FIM with pronto=1; each ACERTOU lasts exactly 3 cycles.
REQ-020 modo=0, no input after start -> TIMEOUT_FIM exactly 8 AGUARDA cycles later; timeout=1, pronto=1, score=0.
REQ-021 fez_jogada on the 8th AGUARDA cycle -> REGISTRA next, no timeout.
REQ-022 modo=1, plays wrong, right, wrong -> vidas 2, 1, 1, 0; FIM after the third result; score=1, endereco=2.
REQ-023 modo=1, one expiry -> ERROU with timeout=1 and errou=1, vidas=1, then PROXIMA; toggling modo mid-game has no effect.
REQ-024 reset=0 pulse while in ACERTOU -> immediate INICIAL, score=0, vidas=2, db_estado=0; the next iniciar starts a fresh game.

Source files
------------

// File: rtl/unidade_controle_param_pkg.sv
// Shared game constants: state codes, the invalid-state display code,
// default parameter values and a width helper used by the control unit.
package unidade_controle_param_pkg;

  localparam int N_JOGADAS_PADRAO   = 16;
  localparam int T_TIMEOUT_PADRAO   = 5000;
  localparam int T_RESULTADO_PADRAO = 1000;
  localparam int N_VIDAS_PADRAO     = 3;

  // State encoding doubles as the db_estado display code.
  typedef enum logic [3:0] {
    ST_INICIAL     = 4'h0,
    ST_PREPARACAO  = 4'h1,
    ST_AGUARDA     = 4'h5,
    ST_REGISTRA    = 4'h6,
    ST_COMPARA     = 4'h7,
    ST_PROXIMA     = 4'h8,
    ST_CONTA       = 4'h9,
    ST_ACERTOU     = 4'hC,
    ST_TIMEOUT_FIM = 4'hD,
    ST_ERROU       = 4'hE,
    ST_FIM         = 4'hF
  } estado_t;

  // Shown on db_estado when the state register holds an unused code.
  localparam logic [3:0] COD_ESTADO_INVALIDO = 4'hB;

  // Bits needed to hold values 0..valor-1, never less than one bit.
  function automatic int largura(input int valor);
    return ($clog2(valor) < 1) ? 1 : $clog2(valor);
  endfunction

endpackage

// File: rtl/unidade_controle_param_contador_m.sv
// Generic up/down counter used for every counter of the control unit.
// Priority: zera, then carga, then conta. fim flags Q == VAL_FIM; any
// saturation is decided by the caller through the conta input.
module contador_m #(
  parameter int           W         = 4,
  parameter logic [W-1:0] VAL_RESET = '0,
  parameter logic [W-1:0] VAL_FIM   = '1,
  parameter bit           DESCE     = 1'b0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         zera,
  input  logic         conta,
  input  logic         carga,
  input  logic [W-1:0] valor,
  output logic [W-1:0] Q,
  output logic         fim
);

  logic [W-1:0] q_r;

  // Counter register with asynchronous active-low reset to VAL_RESET
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q_r <= VAL_RESET;
    end else if (zera) begin
      q_r <= {W{1'b0}};
    end else if (carga) begin
      q_r <= valor;
    end else if (conta) begin
      q_r <= DESCE ? (q_r - W'(1'b1)) : (q_r + W'(1'b1));
    end
  end

  assign Q   = q_r;
  assign fim = (q_r == VAL_FIM);

endmodule

// File: rtl/unidade_controle_param.sv
// Game control unit: Moore FSM sequencing plays, per-play timeout,
// result display time, score, play index and lives.
module unidade_controle_param
  import unidade_controle_param_pkg::*;
#(
  parameter int N_JOGADAS   = N_JOGADAS_PADRAO,
  parameter int T_TIMEOUT   = T_TIMEOUT_PADRAO,
  parameter int T_RESULTADO = T_RESULTADO_PADRAO,
  parameter int N_VIDAS     = N_VIDAS_PADRAO
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             iniciar,
  input  logic                             modo,
  input  logic                             fez_jogada,
  input  logic                             jogada_igual_memoria,
  output logic                             registraR,
  output logic                             zeraR,
  output logic                             liga_led,
  output logic                             pronto,
  output logic                             acertou,
  output logic                             errou,
  output logic                             timeout,
  output logic [largura(N_JOGADAS)-1:0]    endereco,
  output logic [largura(N_JOGADAS+1)-1:0]  score,
  output logic [largura(N_VIDAS+1)-1:0]    vidas,
  output logic [3:0]                       db_estado
);

  localparam int W_END   = largura(N_JOGADAS);
  localparam int W_SCORE = largura(N_JOGADAS + 1);
  localparam int W_VIDAS = largura(N_VIDAS + 1);
  localparam int W_TO    = largura(T_TIMEOUT);
  localparam int W_RES   = largura(T_RESULTADO);

  estado_t estado_r;
  estado_t proximo_s;
  logic    modo_r;
  logic    erro_por_tempo_r;

  logic [W_TO-1:0]  cont_to_s;
  logic [W_RES-1:0] cont_res_s;
  logic             fim_to_s;
  logic             fim_res_s;
  logic             fim_end_s;
  logic             score_cheio_s;
  logic             vidas_zero_s;

  logic fim_jogo_s;
  logic expirou_s;
  logic entra_erro_s;

  // The game ends on the last address, or when lives run out in lives mode.
  assign fim_jogo_s   = fim_end_s || (modo_r && vidas_zero_s);
  // The play timer ran out and no play arrived on that same cycle.
  assign expirou_s    = (estado_r == ST_AGUARDA) && fim_to_s && !fez_jogada;
  assign entra_erro_s = (proximo_s == ST_ERROU) && (estado_r != ST_ERROU);

  // State register with asynchronous active-low reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_r <= ST_INICIAL;
    end else begin
      estado_r <= proximo_s;
    end
  end

  // Next-state logic
  always_comb begin
    proximo_s = estado_r;
    case (estado_r)
      ST_INICIAL: begin
        if (iniciar) proximo_s = ST_PREPARACAO;
        else         proximo_s = ST_INICIAL;
      end
      ST_PREPARACAO: proximo_s = ST_AGUARDA;
      ST_AGUARDA: begin
        if (fez_jogada)    proximo_s = ST_REGISTRA;
        else if (fim_to_s) proximo_s = modo_r ? ST_ERROU : ST_TIMEOUT_FIM;
        else               proximo_s = ST_AGUARDA;
      end
      ST_REGISTRA: proximo_s = ST_COMPARA;
      ST_COMPARA: begin
        if (jogada_igual_memoria) proximo_s = ST_CONTA;
        else                      proximo_s = ST_ERROU;
      end
      ST_CONTA: proximo_s = ST_ACERTOU;
      ST_ACERTOU, ST_ERROU: begin
        if (fim_res_s) proximo_s = fim_jogo_s ? ST_FIM : ST_PROXIMA;
        else           proximo_s = estado_r;
      end
      ST_PROXIMA: proximo_s = ST_AGUARDA;
      ST_FIM, ST_TIMEOUT_FIM: begin
        if (iniciar) proximo_s = ST_INICIAL;
        else         proximo_s = estado_r;
      end
      default: proximo_s = ST_INICIAL;
    endcase
  end

  // Moore output decode from the current state
  always_comb begin
    registraR = 1'b0;
    zeraR     = 1'b0;
    liga_led  = 1'b0;
    acertou   = 1'b0;
    errou     = 1'b0;
    pronto    = 1'b0;
    timeout   = 1'b0;
    db_estado = estado_r;
    case (estado_r)
      ST_INICIAL, ST_PREPARACAO, ST_PROXIMA: zeraR = 1'b1;
      ST_AGUARDA:  liga_led  = 1'b1;
      ST_REGISTRA: registraR = 1'b1;
      ST_COMPARA, ST_CONTA: begin
        registraR = 1'b0;
      end
      ST_ACERTOU: begin
        zeraR   = 1'b1;
        acertou = 1'b1;
      end
      ST_ERROU: begin
        zeraR   = 1'b1;
        errou   = 1'b1;
        timeout = erro_por_tempo_r;
      end
      ST_FIM: pronto = 1'b1;
      ST_TIMEOUT_FIM: begin
        pronto  = 1'b1;
        timeout = 1'b1;
      end
      default: db_estado = COD_ESTADO_INVALIDO;
    endcase
  end

  // Game mode is captured only when a game is requested from INICIAL
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      modo_r <= 1'b0;
    end else if ((estado_r == ST_INICIAL) && iniciar) begin
      modo_r <= modo;
    end
  end

  // Remember whether the current ERROU visit was caused by play-timer expiry
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      erro_por_tempo_r <= 1'b0;
    end else if (entra_erro_s) begin
      erro_por_tempo_r <= (estado_r == ST_AGUARDA);
    end
  end

  // Play timer: counts AGUARDA cycles, holds at its last value on expiry
  contador_m #(
    .W(W_TO), .VAL_RESET({W_TO{1'b0}}), .VAL_FIM(W_TO'(T_TIMEOUT - 1)), .DESCE(1'b0)
  ) u_cont_timeout (
    .clock(clock), .reset(reset),
    .zera((estado_r == ST_PREPARACAO) || (estado_r == ST_PROXIMA) ||
          (estado_r == ST_REGISTRA)),
    .conta((estado_r == ST_AGUARDA) && !fim_to_s),
    .carga(1'b0), .valor({W_TO{1'b0}}),
    .Q(cont_to_s), .fim(fim_to_s)
  );

  // Result timer: measures how long ACERTOU / ERROU are shown
  contador_m #(
    .W(W_RES), .VAL_RESET({W_RES{1'b0}}), .VAL_FIM(W_RES'(T_RESULTADO - 1)), .DESCE(1'b0)
  ) u_cont_resultado (
    .clock(clock), .reset(reset),
    .zera((estado_r == ST_REGISTRA) || (expirou_s && modo_r)),
    .conta(((estado_r == ST_ACERTOU) || (estado_r == ST_ERROU)) && !fim_res_s),
    .carga(1'b0), .valor({W_RES{1'b0}}),
    .Q(cont_res_s), .fim(fim_res_s)
  );

  // Play index
  contador_m #(
    .W(W_END), .VAL_RESET({W_END{1'b0}}), .VAL_FIM(W_END'(N_JOGADAS - 1)), .DESCE(1'b0)
  ) u_cont_endereco (
    .clock(clock), .reset(reset),
    .zera(estado_r == ST_PREPARACAO),
    .conta((estado_r == ST_PROXIMA) && !fim_end_s),
    .carga(1'b0), .valor({W_END{1'b0}}),
    .Q(endereco), .fim(fim_end_s)
  );

  // Correct plays; tops out at N_JOGADAS
  contador_m #(
    .W(W_SCORE), .VAL_RESET({W_SCORE{1'b0}}), .VAL_FIM(W_SCORE'(N_JOGADAS)), .DESCE(1'b0)
  ) u_cont_score (
    .clock(clock), .reset(reset),
    .zera(estado_r == ST_PREPARACAO),
    .conta((estado_r == ST_CONTA) && !score_cheio_s),
    .carga(1'b0), .valor({W_SCORE{1'b0}}),
    .Q(score), .fim(score_cheio_s)
  );

  // Remaining lives: loaded at game start, lost on each error in lives mode
  contador_m #(
    .W(W_VIDAS), .VAL_RESET(W_VIDAS'(N_VIDAS)), .VAL_FIM({W_VIDAS{1'b0}}), .DESCE(1'b1)
  ) u_cont_vidas (
    .clock(clock), .reset(reset),
    .zera(1'b0),
    .conta(modo_r && entra_erro_s && !vidas_zero_s),
    .carga(estado_r == ST_PREPARACAO), .valor(W_VIDAS'(N_VIDAS)),
    .Q(vidas), .fim(vidas_zero_s)
  );

endmodule
